// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier: shift-add product, then remainder via the downstream divider.
// Optional MOD_MUL_BYPASS_EN skips the divider when the product is already below the modulus.
module mod_mul_seq #(
    parameter int nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*nbits-1:0] istream_msg,
    input  logic               istream_val,
    output logic               istream_rdy,
    output logic [nbits-1:0]   ostream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [2*nbits:0]   div_istream_msg,
    output logic               div_istream_val,
    input  logic               div_istream_rdy,
    input  logic [nbits-1:0]   div_ostream_msg,
    input  logic               div_ostream_val,
    output logic               div_ostream_rdy
);
    localparam int HB = nbits / 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL      = 3'd1,
        DIV_REQ  = 3'd2,
        DIV_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [nbits-1:0] mcand_q, mcand_d;
    logic [HB-1:0]    mplier_q, mplier_d;
    logic [nbits-1:0] prod_q, prod_d;
    logic [nbits-1:0] modn_q, modn_d;
    logic [nbits-1:0] result_q, result_d;

    logic [HB-1:0]    in_opa;
    logic [HB-1:0]    in_opb;
    logic [nbits-1:0] in_modn;
    logic             bypass;

    assign in_opa  = istream_msg[2*nbits-1 -: HB];
    assign in_opb  = istream_msg[nbits +: HB];
    assign in_modn = istream_msg[nbits-1:0];

`ifdef MOD_MUL_BYPASS_EN
    assign bypass = (prod_q < modn_q);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            modn_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            modn_q   <= modn_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        modn_d   = modn_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (istream_val) begin
                    mcand_d  = {{HB{1'b0}}, in_opa};
                    mplier_d = in_opb;
                    prod_d   = '0;
                    modn_d   = in_modn;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (mplier_q == '0) begin
                    // A zero modulus returns the raw product and never reaches the divider.
                    if (modn_q == '0 || bypass) begin
                        result_d = prod_q;
                        state_d  = DONE;
                    end else begin
                        state_d  = DIV_REQ;
                    end
                end else begin
                    prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
            end
            DIV_REQ: begin
                if (div_istream_rdy) state_d = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (div_ostream_val) begin
                    result_d = div_ostream_msg;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (ostream_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, held low for as long as reset is asserted.
    assign istream_rdy     = reset && (state_q == IDLE);
    assign div_istream_val = reset && (state_q == DIV_REQ);
    assign div_ostream_rdy = reset && (state_q == DIV_WAIT);
    assign ostream_val     = reset && (state_q == DONE);

    assign div_istream_msg = {1'b1, prod_q, modn_q};
    assign ostream_msg     = result_q;

endmodule
